chimera_clu_pwr_seq: RTL
========================

# chimera_clu_pwr_seq

Per-cluster power sequencer for the Chimera cluster domain. It is a parametrised successor to the fixed five-cluster, register-driven clock-gate/isolate/reset wiring around the cluster domain. For each of `NumClusters` clusters it turns a level power request into an ordered sequence of clock enable, reset, and AXI isolation handshake, with timeout detection. It sits in the SoC clock domain between the top-level config registers and the cluster-domain clock gates, `rst_sync_ni` and `isolate_i`/`isolate_o`.

## Interface
- `NumClusters`, 5: number of independent channels (≥1).
- `RstCycles`, 4: cycles the cluster reset is held with the clock running, on power-up and power-down (≥1).
- `IsoTimeout`, 16: maximum cycles to wait for an isolation acknowledge before error (≥1).
- `soc_clk_i`  in  1  SoC clock; the block's only clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `pwr_req_i`  in  NumClusters  level request per cluster: 1 = on, 0 = off.
- `err_clr_i`  in  NumClusters  per-cluster clear for the error state, one-cycle pulse.
- `iso_ack_i`  in  NumClusters  isolation status from the cluster domain: 1 = isolated and drained.
- `clk_en_o`  out  NumClusters  enable to the cluster clock gate.
- `rst_no`  out  NumClusters  cluster reset, active-low.
- `iso_en_o`  out  NumClusters  isolation request to the cluster domain.
- `on_o`  out  NumClusters  1 while the cluster is in ON.
- `busy_o`  out  NumClusters  1 while the cluster is in a transitional state.
- `err_o`  out  NumClusters  1 while the cluster is in ERR.
- `done_o`  out  NumClusters  one-cycle pulse on entering ON or OFF from a transition.

## Operation
- There is one independent FSM per cluster, with a shared counter width of $clog2(max(RstCycles, IsoTimeout)+1). Channels never interact.
- All outputs are decoded from the state and counter flops only. There is no combinational path from any input to any output.
- Per-state outputs, listed as (clk_en, rst_n, iso_en):
  - OFF (0,0,1)
  - PU_RST (1,0,1)
  - PU_DEISO (1,1,0)
  - ON (1,1,0)
  - PD_ISO (1,1,1)
  - PD_RST (1,0,1)
  - ERR (1,1,1)
- Transitions:
  - OFF → PU_RST when `pwr_req_i`=1.
  - PU_RST → PU_DEISO after RstCycles cycles in PU_RST.
  - PU_DEISO → ON when `iso_ack_i`=0.
  - ON → PD_ISO when `pwr_req_i`=0.
  - PD_ISO → PD_RST when `iso_ack_i`=1.
  - PD_RST → OFF after RstCycles cycles in PD_RST.
  - PU_DEISO or PD_ISO → ERR when no acknowledge arrives within IsoTimeout cycles.
  - ERR → PD_RST on `err_clr_i`=1. Recovery is always a forced shutdown; a held request re-powers afterwards.
- `pwr_req_i` is sampled only in OFF and ON. Changes during a transition are ignored until it completes, so a request that drops mid-power-up gives ON followed by PD_ISO.
- The counter clears on every state entry and increments each cycle in PU_RST, PD_RST, PU_DEISO and PD_ISO.
- `err_clr_i` is ignored outside ERR.
- `busy_o` is 1 in PU_RST, PU_DEISO, PD_ISO and PD_RST.

## Timing
- Reset (rst_i=1 at an edge): every FSM goes to OFF and the counter to 0.
  - Outputs: clk_en_o=0, rst_no=0, iso_en_o=1, on_o=0, busy_o=0, err_o=0, done_o=0.
  - Reset mid-sequence aborts immediately to OFF with no done pulse.
- Edge k samples `pwr_req_i`=1 in OFF:
  - Cycles k+1 … k+RstCycles: PU_RST.
  - Cycle k+RstCycles+1: PU_DEISO.
  - If ack is already low in that cycle, ON starts at k+RstCycles+2 with `done_o`=1 for that single cycle.
  - Minimum power-up latency is RstCycles+2 edges.
- Power-down mirrors power-up: PD_ISO lasts at least 1 cycle, then RstCycles cycles of PD_RST, then OFF with a `done_o` pulse. Minimum latency is RstCycles+2 edges.
- Timeout: ERR is entered on the edge ending the IsoTimeout-th consecutive cycle in the wait state without the required ack level.
  - An ack arriving in that final cycle wins; no ERR.
- `err_clr_i` sampled in ERR at edge e: PD_RST from e+1.
- `done_o` is never asserted for two consecutive cycles and never at reset exit.

## Test plan
- Reset exit with defaults, then `pwr_req_i`[0]=1 at edge 0 and `iso_ack_i`[0] dropping 1 cycle after `iso_en_o` falls:
  - `rst_no`[0] stays 0 for cycles 1–4, `iso_en_o`[0] falls at cycle 5, ON and `done_o` at cycle 7.
  - All other channels remain in reset values.
- From ON, `pwr_req_i`=0 with ack returning after 3 cycles:
  - PD_ISO for 3 cycles, `rst_no`=0 for 4 cycles, then `clk_en_o`=0 and a single `done_o` pulse.
- Power-down with `iso_ack_i` stuck 0:
  - `err_o`=1 exactly 16 cycles after PD_ISO entry, with `clk_en_o`=1 and `iso_en_o`=1.
  - `err_clr_i` pulse → PD_RST for 4 cycles, then OFF.
- Ack rising in the 16th wait cycle → PD_RST, `err_o` stays 0.
- Request pulsed high for 1 cycle in OFF:
  - The full power-up completes to ON, then an immediate power-down to OFF.
  - Exactly two `done_o` pulses.
- `rst_i` asserted during PU_RST on cluster 2 while cluster 0 is ON:
  - Both channels are in OFF reset values at the next edge.
  - No `done_o`.
  - `NumClusters`=8 with staggered requests shows independent, non-interfering timing.

Source files
------------

// File: rtl/chimera_clu_pwr_seq_if.sv
// Per-cluster power request/status bundle between the config registers and
// the cluster-domain clock gates, resets and AXI isolation cells.
interface chimera_clu_pwr_seq_if #(
  parameter int NumClusters = 5
);
  logic [NumClusters-1:0] pwr_req_i;
  logic [NumClusters-1:0] err_clr_i;
  logic [NumClusters-1:0] iso_ack_i;
  logic [NumClusters-1:0] clk_en_o;
  logic [NumClusters-1:0] rst_no;
  logic [NumClusters-1:0] iso_en_o;
  logic [NumClusters-1:0] on_o;
  logic [NumClusters-1:0] busy_o;
  logic [NumClusters-1:0] err_o;
  logic [NumClusters-1:0] done_o;

  // Requester side: config registers plus the isolation acknowledge return.
  modport master (
    output pwr_req_i, err_clr_i, iso_ack_i,
    input  clk_en_o, rst_no, iso_en_o, on_o, busy_o, err_o, done_o
  );

  // Sequencer side.
  modport slave (
    input  pwr_req_i, err_clr_i, iso_ack_i,
    output clk_en_o, rst_no, iso_en_o, on_o, busy_o, err_o, done_o
  );
endinterface

// File: rtl/chimera_clu_pwr_seq.sv
// Per-cluster power sequencer: orders clock enable, reset release and AXI
// isolation for each cluster, with isolation-acknowledge timeout detection.
module chimera_clu_pwr_seq #(
  parameter int NumClusters = 5,
  parameter int RstCycles   = 4,
  parameter int IsoTimeout  = 16
) (
  input logic                  soc_clk_i,
  input logic                  rst_i,
  chimera_clu_pwr_seq_if.slave bus
);

  localparam int CntMax = (RstCycles > IsoTimeout) ? RstCycles : IsoTimeout;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] RstLast = CntW'(RstCycles - 1);
  localparam logic [CntW-1:0] IsoLast = CntW'(IsoTimeout - 1);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    PU_RST   = 3'd1,
    PU_DEISO = 3'd2,
    ON       = 3'd3,
    PD_ISO   = 3'd4,
    PD_RST   = 3'd5,
    ERR      = 3'd6
  } state_e;

  for (genvar g = 0; g < NumClusters; g++) begin : g_ch
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            clk_en, rst_n, iso_en, on, busy, err;

    always_ff @(posedge soc_clk_i) begin
      if (rst_i) begin
        state_q <= OFF;
        cnt_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        done_q  <= done_d;
      end
    end

    // The request is only looked at in the two stable states, so a transition
    // always runs to completion before the opposite one can start.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
        OFF:      if (bus.pwr_req_i[g]) state_d = PU_RST;
        PU_RST:   if (cnt_q == RstLast) state_d = PU_DEISO;
        PU_DEISO: begin
          if (!bus.iso_ack_i[g])     state_d = ON;
          else if (cnt_q == IsoLast) state_d = ERR;
        end
        ON:       if (!bus.pwr_req_i[g]) state_d = PD_ISO;
        PD_ISO: begin
          if (bus.iso_ack_i[g])      state_d = PD_RST;
          else if (cnt_q == IsoLast) state_d = ERR;
        end
        PD_RST:   if (cnt_q == RstLast) state_d = OFF;
        ERR:      if (bus.err_clr_i[g]) state_d = PD_RST;
        default:  state_d = OFF;
      endcase

      if (state_d != state_q) begin
        cnt_d = '0;
      end else if (state_q inside {PU_RST, PU_DEISO, PD_ISO, PD_RST}) begin
        cnt_d = cnt_q + CntW'(1);
      end

      done_d = ((state_q == PU_DEISO) && (state_d == ON)) ||
               ((state_q == PD_RST)   && (state_d == OFF));
    end

    // Outputs come from flops only, so nothing combinational reaches the pins.
    always_comb begin
      clk_en = 1'b1;
      rst_n  = 1'b1;
      iso_en = 1'b1;
      on     = 1'b0;
      busy   = 1'b0;
      err    = 1'b0;
      unique case (state_q)
        OFF: begin
          clk_en = 1'b0;
          rst_n  = 1'b0;
        end
        PU_RST: begin
          rst_n = 1'b0;
          busy  = 1'b1;
        end
        PU_DEISO: begin
          iso_en = 1'b0;
          busy   = 1'b1;
        end
        ON: begin
          iso_en = 1'b0;
          on     = 1'b1;
        end
        PD_ISO:  busy = 1'b1;
        PD_RST: begin
          rst_n = 1'b0;
          busy  = 1'b1;
        end
        ERR:     err = 1'b1;
        default: begin
          clk_en = 1'b0;
          rst_n  = 1'b0;
        end
      endcase
    end

    assign bus.clk_en_o[g] = clk_en;
    assign bus.rst_no[g]   = rst_n;
    assign bus.iso_en_o[g] = iso_en;
    assign bus.on_o[g]     = on;
    assign bus.busy_o[g]   = busy;
    assign bus.err_o[g]    = err;
    assign bus.done_o[g]   = done_q;
  end

endmodule
